// File: rtl/pixel_unpacker.sv
// pixel_unpacker: AXI-Stream receiver that turns the packed 24-bit RGB stream
// (four pixels in three 32-bit words) back into one pixel per handshake. It
// regenerates x/y coordinates and sof/eol flags, checks line/frame framing and
// counts completed frames.
module pixel_unpacker #(
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int COORD_W = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [31:0]        in_stream_tdata,
    input  logic [3:0]         in_stream_tkeep,
    input  logic               in_stream_tlast,
    input  logic               in_stream_tuser,
    input  logic               in_stream_tvalid,
    output logic               in_stream_tready,
    output logic [7:0]         pix_r,
    output logic [7:0]         pix_g,
    output logic [7:0]         pix_b,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               sof_err,
    output logic               eol_err,
    output logic [15:0]        frame_count
);

    localparam int WPL    = 3 * X_SIZE / 4;
    localparam int WIDX_W = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Word-side state: framing FSM, unpack phase, leftover bytes and counters.
    state_t              state_q, state_d;
    logic [1:0]          ph_q, ph_d;
    logic                drain_q, drain_d;
    logic                tail_q, tail_d;
    logic [23:0]         carry_q, carry_d;
    logic [WIDX_W-1:0]   wordIdx_q, wordIdx_d;
    logic [COORD_W-1:0]  line_q, line_d;

    // Pixel-side state: coordinates of the next pixel to be emitted.
    logic [COORD_W-1:0]  pixX_q, pixX_d;
    logic [COORD_W-1:0]  pixY_q, pixY_d;

    // Output register stage.
    logic                outValid_q, outValid_d;
    logic [7:0]          outR_q, outR_d;
    logic [7:0]          outG_q, outG_d;
    logic [7:0]          outB_q, outB_d;
    logic [COORD_W-1:0]  outX_q, outX_d;
    logic [COORD_W-1:0]  outY_q, outY_d;
    logic                outSof_q, outSof_d;
    logic                outEol_q, outEol_d;
    logic                sofErr_q, sofErr_d;
    logic                eolErr_q, eolErr_d;
    logic [15:0]         frameCount_q, frameCount_d;

    // Combinational helpers.
    logic                slotFree;
    logic                wordFire;
    logic                frameDone;
    logic                sofHit;
    logic                decodeWord;
    logic                abortLine;
    logic                fromOrigin;
    logic                emit;
    logic [7:0]          emR, emG, emB;
    logic [WIDX_W-1:0]   effIdx;
    logic [COORD_W-1:0]  effLine;
    logic [1:0]          effPh;
    logic [COORD_W-1:0]  baseX, baseY;
    logic                unusedKeep;

    // tkeep carries no information here: every byte of every word is used.
    assign unusedKeep = ^in_stream_tkeep;

    assign slotFree  = !outValid_q || pix_ready;
    // tready stays low while a drain pixel is pending and after the last word
    // of a frame until its final pixel has been taken downstream.
    assign in_stream_tready = aresetn &&
                              ((state_q == HUNT) || (!drain_q && !tail_q && slotFree));
    assign wordFire  = in_stream_tvalid && in_stream_tready;
    assign frameDone = (state_q == RUN) && outValid_q && pix_ready && outEol_q &&
                       (outY_q == COORD_W'(Y_SIZE - 1));

    // Next-state logic: framing checks, unpacking, output loading and frame accounting.
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        drain_d      = drain_q;
        tail_d       = tail_q;
        carry_d      = carry_q;
        wordIdx_d    = wordIdx_q;
        line_d       = line_q;
        pixX_d       = pixX_q;
        pixY_d       = pixY_q;
        outValid_d   = outValid_q;
        outR_d       = outR_q;
        outG_d       = outG_q;
        outB_d       = outB_q;
        outX_d       = outX_q;
        outY_d       = outY_q;
        outSof_d     = outSof_q;
        outEol_d     = outEol_q;
        sofErr_d     = 1'b0;
        eolErr_d     = 1'b0;
        frameCount_d = frameCount_q;
        sofHit       = 1'b0;
        decodeWord   = 1'b0;
        abortLine    = 1'b0;
        fromOrigin   = 1'b0;
        emit         = 1'b0;
        emR          = 8'h00;
        emG          = 8'h00;
        emB          = 8'h00;
        effIdx       = wordIdx_q;
        effLine      = line_q;
        effPh        = ph_q;
        baseX        = pixX_q;
        baseY        = pixY_q;

        if (slotFree) begin
            outValid_d = 1'b0;
        end

        if (state_q == HUNT) begin
            // A tuser word that finds the output register still occupied is dropped
            // like any other hunted word, so the pending pixel is never overwritten.
            if (wordFire && in_stream_tuser && slotFree) begin
                decodeWord = 1'b1;
                fromOrigin = 1'b1;
                effIdx     = '0;
                effLine    = '0;
                effPh      = 2'd0;
                state_d    = RUN;
            end
        end else begin
            if (drain_q) begin
                if (slotFree) begin
                    emit    = 1'b1;
                    emB     = carry_q[7:0];
                    emG     = carry_q[15:8];
                    emR     = carry_q[23:16];
                    drain_d = 1'b0;
                end
            end else if (wordFire) begin
                sofHit = in_stream_tuser && ((wordIdx_q != '0) || (line_q != '0));
                if (sofHit) begin
                    effIdx     = '0;
                    effLine    = '0;
                    effPh      = 2'd0;
                    fromOrigin = 1'b1;
                end
                sofErr_d = sofHit;
                if (in_stream_tlast != (effIdx == WIDX_W'(WPL - 1))) begin
                    eolErr_d  = 1'b1;
                    abortLine = 1'b1;
                end else begin
                    decodeWord = 1'b1;
                end
            end
        end

        if (decodeWord) begin
            emit = 1'b1;
            case (effPh)
                2'd0: begin
                    emB     = in_stream_tdata[7:0];
                    emG     = in_stream_tdata[15:8];
                    emR     = in_stream_tdata[23:16];
                    carry_d = {16'h0000, in_stream_tdata[31:24]};
                    ph_d    = 2'd1;
                end
                2'd1: begin
                    emB     = carry_q[7:0];
                    emG     = in_stream_tdata[7:0];
                    emR     = in_stream_tdata[15:8];
                    carry_d = {8'h00, in_stream_tdata[31:16]};
                    ph_d    = 2'd2;
                end
                default: begin
                    emB     = carry_q[7:0];
                    emG     = carry_q[15:8];
                    emR     = in_stream_tdata[7:0];
                    carry_d = in_stream_tdata[31:8];
                    ph_d    = 2'd0;
                    drain_d = 1'b1;
                end
            endcase
            if (effIdx == WIDX_W'(WPL - 1)) begin
                wordIdx_d = '0;
                if (effLine == COORD_W'(Y_SIZE - 1)) begin
                    line_d = '0;
                    tail_d = 1'b1;
                end else begin
                    line_d = effLine + 1'b1;
                end
            end else begin
                wordIdx_d = effIdx + 1'b1;
                line_d    = effLine;
            end
        end

        if (emit) begin
            if (fromOrigin) begin
                baseX = '0;
                baseY = '0;
            end
            outValid_d = 1'b1;
            outR_d     = emR;
            outG_d     = emG;
            outB_d     = emB;
            outX_d     = baseX;
            outY_d     = baseY;
            outSof_d   = (baseX == '0) && (baseY == '0);
            outEol_d   = (baseX == COORD_W'(X_SIZE - 1));
            if (baseX == COORD_W'(X_SIZE - 1)) begin
                pixX_d = '0;
                pixY_d = (baseY == COORD_W'(Y_SIZE - 1)) ? '0 : baseY + 1'b1;
            end else begin
                pixX_d = baseX + 1'b1;
                pixY_d = baseY;
            end
        end

        if (frameDone) begin
            frameCount_d = frameCount_q + 1'b1;
        end

        if (abortLine || frameDone) begin
            state_d   = HUNT;
            ph_d      = 2'd0;
            drain_d   = 1'b0;
            tail_d    = 1'b0;
            carry_d   = '0;
            wordIdx_d = '0;
            line_d    = '0;
            pixX_d    = '0;
            pixY_d    = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= HUNT;
            ph_q         <= 2'd0;
            drain_q      <= 1'b0;
            tail_q       <= 1'b0;
            carry_q      <= '0;
            wordIdx_q    <= '0;
            line_q       <= '0;
            pixX_q       <= '0;
            pixY_q       <= '0;
            outValid_q   <= 1'b0;
            outR_q       <= 8'h00;
            outG_q       <= 8'h00;
            outB_q       <= 8'h00;
            outX_q       <= '0;
            outY_q       <= '0;
            outSof_q     <= 1'b0;
            outEol_q     <= 1'b0;
            sofErr_q     <= 1'b0;
            eolErr_q     <= 1'b0;
            frameCount_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            drain_q      <= drain_d;
            tail_q       <= tail_d;
            carry_q      <= carry_d;
            wordIdx_q    <= wordIdx_d;
            line_q       <= line_d;
            pixX_q       <= pixX_d;
            pixY_q       <= pixY_d;
            outValid_q   <= outValid_d;
            outR_q       <= outR_d;
            outG_q       <= outG_d;
            outB_q       <= outB_d;
            outX_q       <= outX_d;
            outY_q       <= outY_d;
            outSof_q     <= outSof_d;
            outEol_q     <= outEol_d;
            sofErr_q     <= sofErr_d;
            eolErr_q     <= eolErr_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign pix_r       = outR_q;
    assign pix_g       = outG_q;
    assign pix_b       = outB_q;
    assign pix_x       = outX_q;
    assign pix_y       = outY_q;
    assign pix_sof     = outSof_q;
    assign pix_eol     = outEol_q;
    assign pix_valid   = outValid_q;
    assign sof_err     = sofErr_q;
    assign eol_err     = eolErr_q;
    assign frame_count = frameCount_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: directed bench for pixel_unpacker with an 8x2 frame.
// Frame bytes are 0x00..0x2F, so pixel p is expected as B=3p, G=3p+1, R=3p+2.
module tb_pixel_unpacker;

    localparam int XS = 8;
    localparam int YS = 2;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [31:0]   in_stream_tdata;
    logic [3:0]    in_stream_tkeep;
    logic          in_stream_tlast;
    logic          in_stream_tuser;
    logic          in_stream_tvalid;
    logic          in_stream_tready;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic [CW-1:0] pix_x, pix_y;
    logic          pix_sof, pix_eol, pix_valid, pix_ready;
    logic          sof_err, eol_err;
    logic [15:0]   frame_count;

    int            totalChecks = 0;
    int            badChecks = 0;
    int            expQ[$];
    int            sofErrCnt = 0;
    int            eolErrCnt = 0;
    logic          heldValid = 1'b0;
    logic [23:0]   heldPix = 24'h0;
    logic          readyToggle = 1'b0;
    logic [3:0]    readyPat = 4'b1001;

    pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .COORD_W(CW)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .in_stream_tdata (in_stream_tdata),
        .in_stream_tkeep (in_stream_tkeep),
        .in_stream_tlast (in_stream_tlast),
        .in_stream_tuser (in_stream_tuser),
        .in_stream_tvalid(in_stream_tvalid),
        .in_stream_tready(in_stream_tready),
        .pix_r           (pix_r),
        .pix_g           (pix_g),
        .pix_b           (pix_b),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .sof_err         (sof_err),
        .eol_err         (eol_err),
        .frame_count     (frame_count)
    );

    always #5 aclk = ~aclk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] wordOf(input int k);
        return {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
    endfunction

    // Presents one word (after an optional tvalid gap) and waits for its handshake.
    // Entered and left 2ns after a rising edge.
    task automatic applyStimulus(input logic [31:0] data, input logic user,
                                 input logic last, input int gap, input logic drainChk);
        int   waitCnt;
        logic hs;
        in_stream_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge aclk);
            #2;
        end
        in_stream_tdata  = data;
        in_stream_tuser  = user;
        in_stream_tlast  = last;
        in_stream_tvalid = 1'b1;
        waitCnt = 0;
        hs = 1'b0;
        while (!hs && waitCnt < 50) begin
            @(negedge aclk);
            hs = in_stream_tready;
            @(posedge aclk);
            #2;
            waitCnt++;
        end
        if (!hs) checkOutput("handshakeTimeout", 32'(waitCnt), 0);
        in_stream_tvalid = 1'b0;
        if (drainChk) checkOutput("drainReady", 32'(in_stream_tready), 0);
    endtask

    // Sends the reference 8x2 frame; gapEvery>0 inserts tvalid gaps.
    task automatic sendFrame(input int gapEvery);
        for (int p = 0; p < XS * YS; p++) expQ.push_back(p);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(wordOf(k), (k == 0), (k == 5) || (k == 11),
                          (gapEvery > 0 && (k % gapEvery) == 1) ? 2 : 0, (k % 3) == 2);
        end
    endtask

    // Waits (bounded) until every expected pixel has been delivered.
    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge aclk);
            #2;
            n++;
        end
        checkOutput("drainDone", 32'(expQ.size()), 0);
        repeat (3) begin
            @(posedge aclk);
            #2;
        end
    endtask

    // Downstream ready: constant 1, or the 1,0,0,1 pattern when enabled.
    initial begin
        int k = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #2;
            if (readyToggle) begin
                pix_ready = readyPat[k];
                k = (k + 1) % 4;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    // Output monitor: compares delivered pixels against the expected queue,
    // checks hold stability under stall and counts error pulses.
    always @(negedge aclk) begin
        int p;
        if (!aresetn) begin
            heldValid = 1'b0;
        end else begin
            if (heldValid) begin
                checkOutput("stallValid", 32'(pix_valid), 1);
                checkOutput("stallData", {8'h00, pix_r, pix_g, pix_b}, {8'h00, heldPix});
            end
            if (sof_err) sofErrCnt++;
            if (eol_err) eolErrCnt++;
            if (pix_valid && pix_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraPix", 32'(pix_valid), 0);
                end else begin
                    p = expQ.pop_front();
                    checkOutput("pixRGB", {8'h00, pix_r, pix_g, pix_b},
                                {8'h00, 8'(3 * p + 2), 8'(3 * p + 1), 8'(3 * p)});
                    checkOutput("pixX", 32'(pix_x), p % XS);
                    checkOutput("pixY", 32'(pix_y), p / XS);
                    checkOutput("pixSof", 32'(pix_sof), (p == 0) ? 1 : 0);
                    checkOutput("pixEol", 32'(pix_eol), ((p % XS) == XS - 1) ? 1 : 0);
                end
            end
            heldValid = pix_valid && !pix_ready;
            heldPix   = {pix_r, pix_g, pix_b};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        aresetn          = 1'b0;
        in_stream_tdata  = 32'h0;
        in_stream_tkeep  = 4'hF;
        in_stream_tlast  = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tvalid = 1'b0;

        // Reset state.
        @(posedge aclk);
        #2;
        checkOutput("rstTready", 32'(in_stream_tready), 0);
        checkOutput("rstValid", 32'(pix_valid), 0);
        checkOutput("rstFrames", 32'(frame_count), 0);
        checkOutput("rstErrs", {30'h0, sof_err, eol_err}, 0);
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #2;

        // 1: clean frame at full rate.
        sendFrame(0);
        waitDrain();
        checkOutput("frames1", 32'(frame_count), 1);

        // 2: same frame with ready toggling and tvalid gaps.
        readyToggle = 1'b1;
        sendFrame(4);
        waitDrain();
        readyToggle = 1'b0;
        checkOutput("frames2", 32'(frame_count), 2);

        // 3: idle, three words without tuser (dropped), then a frame.
        repeat (5) begin
            @(posedge aclk);
            #2;
        end
        applyStimulus(32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(32'h12345678, 1'b0, 1'b1, 1, 1'b0);
        applyStimulus(32'hCAFEF00D, 1'b0, 1'b0, 0, 1'b0);
        sendFrame(0);
        waitDrain();
        checkOutput("frames3", 32'(frame_count), 3);

        // 4: tlast on word 3 of line 0, then a good frame.
        for (int p = 0; p < 4; p++) expQ.push_back(p);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(wordOf(k), (k == 0), (k == 3), 0, (k == 2));
        end
        checkOutput("eolPulse", 32'(eol_err), 1);
        checkOutput("huntReady", 32'(in_stream_tready), 1);
        @(posedge aclk);
        #2;
        checkOutput("eolPulseEnd", 32'(eol_err), 0);
        sendFrame(0);
        waitDrain();
        checkOutput("frames4", 32'(frame_count), 4);
        checkOutput("eolCount4", 32'(eolErrCnt), 1);

        // 5: tuser on word 7 restarts the frame.
        for (int p = 0; p < 9; p++) expQ.push_back(p);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(wordOf(k), (k == 0), (k == 5), 0, (k % 3) == 2);
        end
        sendFrame(0);
        waitDrain();
        checkOutput("sofCount5", 32'(sofErrCnt), 1);
        checkOutput("eolCount5", 32'(eolErrCnt), 1);
        checkOutput("frames5", 32'(frame_count), 5);

        // 6: reset right after word 4; pixel 5 must never appear.
        for (int p = 0; p < 5; p++) expQ.push_back(p);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(wordOf(k), (k == 0), 1'b0, 0, (k == 2));
        end
        aresetn = 1'b0;
        #1;
        checkOutput("midRstTready", 32'(in_stream_tready), 0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("postRstValid", 32'(pix_valid), 0);
        checkOutput("postRstFrames", 32'(frame_count), 0);
        @(posedge aclk);
        #2;
        checkOutput("postRstQueue", 32'(expQ.size()), 0);
        sendFrame(0);
        waitDrain();
        checkOutput("frames6", 32'(frame_count), 1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- AXI-Stream receiver for the video pixel stream produced by the pixel packer: 24-bit RGB pixels packed four-per-three 32-bit words, tuser marking start of frame, tlast marking end of line.
- Unpacks words back into one pixel per handshake, with regenerated x/y coordinates and sof/eol flags.
- Checks frame framing and flags errors.
- Sits on the loopback/test path ahead of frame-compare logic and consumes out_stream_* of the pixel generator.

Parameters:
- X_SIZE, 640, pixels per line; must be a multiple of 4.
- Y_SIZE, 480, lines per frame.
- COORD_W, 16, width of the x/y coordinate outputs.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- in_stream_tdata  in  32  packed pixel bytes.
- in_stream_tkeep  in  4  ignored; all bytes are assumed valid.
- in_stream_tlast  in  1  last word of line.
- in_stream_tuser  in  1  first word of frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid&tready.
- pix_r, pix_g, pix_b  out  8 each  unpacked pixel.
- pix_x, pix_y  out  COORD_W each  pixel coordinates.
- pix_sof  out  1  pixel (0,0).
- pix_eol  out  1  pix_x == X_SIZE-1.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  downstream accepts pixel.
- sof_err  out  1  one-cycle pulse: tuser seen mid-frame.
- eol_err  out  1  one-cycle pulse: tlast missing, or tlast early.
- frame_count  out  16  completed frames, wraps at 0xFFFF to 0.

Behaviour:
Packing format:
- Byte stream is B0,G0,R0,B1,G1,R1,... with byte n at tdata[8*(n%4)+:8].
- Word 0 = {B1,R0,G0,B0}.
- Word 1 = {G2,B2,R1,G1}.
- Word 2 = {R3,G3,B3,R2}.
- WPL = 3*X_SIZE/4 words per line.

States:
- HUNT
  - tready=1; words are dropped until tvalid&tuser.
  - That word is processed as word 0 of line 0, and the state moves to RUN.
- RUN
  - Phase counter ph (0,1,2) selects unpacking.
  - A carry register holds leftover bytes: 1 byte after ph0, 2 bytes after ph1.
  - ph0 emits pixel 4k. ph1 emits pixel 4k+1. ph2 emits pixel 4k+2.
  - ph2 then sets drain=1; the next output slot emits pixel 4k+3 from the buffered word while tready=0.
- tready = (state==HUNT) | (!drain & (!pix_valid | pix_ready)).

Output registers:
- Output is a single register stage.
- Latency: word accepted at cycle t, its (first) pixel valid at t+1.
- pix_valid/pixel fields hold steady while pix_valid & !pix_ready.
- Full throughput: 4 pixels per 4 cycles with pix_ready=1 and tvalid=1.

Counters:
- word_idx counts 0..WPL-1 per line; pix_x counts 0..X_SIZE-1; pix_y counts 0..Y_SIZE-1.
- Pixel (X_SIZE-1, Y_SIZE-1) accepted downstream: frame_count+1; return to HUNT with counters cleared.

Framing checks on each accepted word in RUN:
- tuser=1 with (word_idx,line) != (0,0):
  - sof_err pulse.
  - Carry is discarded and counters cleared.
  - The word is restarted as word 0 of line 0. Any pending drain pixel is still emitted first, because tready is low.
- tlast=1 with word_idx != WPL-1: eol_err pulse, go to HUNT, carry discarded.
- tlast=0 with word_idx == WPL-1: eol_err pulse, go to HUNT, carry discarded.
- tuser and tlast errors in the same word: both pulses fire; HUNT wins.
- A pixel already in the output register is still delivered.

Reset values (aresetn=0 at posedge):
- state=HUNT, ph=0, drain=0, counters=0, frame_count=0.
- pix_valid=0, pixel fields=0, sof_err=0, eol_err=0, tready=0 during reset.
- Reset mid-frame aborts immediately; no partial pixel is emitted after reset.

Test Plan:
- X_SIZE=8, Y_SIZE=2, pix_ready=1. Send 12 words, tuser on word 0, tlast on words 5 and 11, with bytes 0x00..0x2F.
  - 16 pixels out: pixel 0 = R02 G01 B00, pixel 3 = R0B G0A B09.
  - x wraps 7→0; pix_eol on x=7; pix_sof only on the first pixel.
  - frame_count=1; no errors.
- Same frame with pix_ready toggling 1,0,0,1 and tvalid gaps.
  - Identical pixel sequence, no drops or duplicates.
  - Pixel fields stable while stalled; tready=0 during each drain cycle.
- Idle stream, then 3 words without tuser, then a valid frame.
  - First 3 words dropped in HUNT; output equals the clean frame.
- tlast on word 3 of line 0.
  - eol_err pulses one cycle later; state returns to HUNT.
  - The next tuser frame decodes correctly.
- tuser asserted on word 7 (mid line 1).
  - sof_err pulse; that word decodes as pixel 0 of line 0 with pix_sof=1.
- aresetn low for 1 cycle after word 4 of a frame.
  - Next cycle pix_valid=0, frame_count=0, state HUNT.
  - A subsequent full frame decodes correctly.
